// File: rtl/mod_counter_chain_pkg.sv
// Shared constants for the cascaded mod-K counter family and the clock designs built on it.
package counter_pkg;
    localparam int DEF_DIGITS    = 4;
    localparam int DEF_W         = 4;
    localparam int DEF_K         = 10;
    localparam int BCD_MOD       = 10;
    localparam int SEXA_TENS_MOD = 6;
endpackage

// File: rtl/mod_counter_chain_digit.sv
// One mod-K digit: steps up or down when enabled, saturating load, one-cycle wrap flag.
module mod_digit
    import counter_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int K = DEF_K
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         step,
    input  logic         Up,
    input  logic         Clear,
    input  logic         Load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         at_term,
    output logic         wrap
);
    localparam logic [W-1:0] TERM = W'(K - 1);

    logic [W-1:0] value_q, value_d;
    logic         wrap_q, wrap_d;

    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        if (Clear) begin
            value_d = '0;
        end else if (Load) begin
            value_d = (load_val > TERM) ? TERM : load_val;
        end else if (step) begin
            if (Up) begin
                if (value_q == TERM) begin
                    value_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    value_d = value_q + W'(1);
                end
            end else begin
                if (value_q == '0) begin
                    value_d = TERM;
                    wrap_d  = 1'b1;
                end else begin
                    value_d = value_q - W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
        end
    end

    // Terminal value in the current direction; feeds the next digit's step enable.
    assign at_term = Up ? (value_q == TERM) : (value_q == '0);
    assign value   = value_q;
    assign wrap    = wrap_q;
endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of DIGITS mod-K digits with a single-cycle combinational carry/borrow chain.
module mod_counter_chain
    import counter_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int W      = DEF_W,
    parameter int K      = DEF_K
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                En,
    input  logic                Up,
    input  logic                Clear,
    input  logic                Load,
    input  logic [DIGITS*W-1:0] Load_val,
    output logic [DIGITS*W-1:0] Q,
    output logic [DIGITS-1:0]   Digit_wrap,
    output logic                Rollover
);
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] at_term;
    logic              rollover_q, rollover_d;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign step[i] = En;
        end else begin : g_upper
            // A digit moves only when every lower digit is at its terminal value.
            assign step[i] = step[i-1] & at_term[i-1];
        end

        mod_digit #(.W(W), .K(K)) u_digit (
            .Clock    (Clock),
            .Reset_n  (Reset_n),
            .step     (step[i]),
            .Up       (Up),
            .Clear    (Clear),
            .Load     (Load),
            .load_val (Load_val[i*W +: W]),
            .value    (Q[i*W +: W]),
            .at_term  (at_term[i]),
            .wrap     (Digit_wrap[i])
        );
    end

    always_comb begin
        rollover_d = 1'b0;
        if (!Clear && !Load)
            rollover_d = step[DIGITS-1] & at_term[DIGITS-1];
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) rollover_q <= 1'b0;
        else          rollover_q <= rollover_d;
    end

    assign Rollover = rollover_q;
endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed checks of a 2-digit BCD chain plus a single mod-6 digit instance.
module tb_mod_counter_chain;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       En = 0, Up = 0, Clear = 0, Load = 0;
    logic [7:0] Load_val = '0;
    logic [7:0] Q;
    logic [1:0] Digit_wrap;
    logic       Rollover;

    logic       En6 = 0, Up6 = 0, Clear6 = 0, Load6 = 0;
    logic [2:0] Load_val6 = '0;
    logic [2:0] Q6;
    logic [0:0] Digit_wrap6;
    logic       Rollover6;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    mod_counter_chain #(.DIGITS(2), .W(4), .K(10)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .En(En), .Up(Up), .Clear(Clear),
        .Load(Load), .Load_val(Load_val), .Q(Q), .Digit_wrap(Digit_wrap),
        .Rollover(Rollover)
    );

    mod_counter_chain #(.DIGITS(1), .W(3), .K(6)) dut6 (
        .Clock(Clock), .Reset_n(Reset_n), .En(En6), .Up(Up6), .Clear(Clear6),
        .Load(Load6), .Load_val(Load_val6), .Q(Q6), .Digit_wrap(Digit_wrap6),
        .Rollover(Rollover6)
    );

    typedef struct {
        logic       clr, ld, en, up;
        logic [7:0] lv;
        logic [7:0] q;
        logic [1:0] dw;
        logic       ro;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_in(input logic c, input logic l, input logic e, input logic u, input logic [7:0] v);
        Clear = c; Load = l; En = e; Up = u; Load_val = v;
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        //          clr ld en up  lv     q      dw     ro
        vecs[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 2'b00, 0};
        vecs[1]  = '{0, 1, 0, 0, 8'hC5, 8'h95, 2'b00, 0};
        vecs[2]  = '{1, 1, 0, 0, 8'h33, 8'h00, 2'b00, 0};
        vecs[3]  = '{0, 0, 1, 0, 8'h00, 8'h99, 2'b11, 1};
        vecs[4]  = '{0, 0, 1, 0, 8'h00, 8'h98, 2'b00, 0};
        vecs[5]  = '{0, 0, 1, 1, 8'h00, 8'h99, 2'b00, 0};
        vecs[6]  = '{0, 0, 1, 1, 8'h00, 8'h00, 2'b11, 1};
        vecs[7]  = '{0, 1, 0, 0, 8'h99, 8'h99, 2'b00, 0};
        vecs[8]  = '{1, 0, 1, 1, 8'h00, 8'h00, 2'b00, 0};
        vecs[9]  = '{0, 1, 0, 0, 8'h19, 8'h19, 2'b00, 0};
        vecs[10] = '{0, 0, 1, 1, 8'h00, 8'h20, 2'b01, 0};
        vecs[11] = '{0, 0, 1, 0, 8'h00, 8'h19, 2'b01, 0};
        vecs[12] = '{0, 0, 0, 0, 8'h00, 8'h19, 2'b00, 0};
        vecs[13] = '{0, 1, 0, 0, 8'hFF, 8'h99, 2'b00, 0};
        vecs[14] = '{0, 1, 1, 1, 8'h09, 8'h09, 2'b00, 0};
        vecs[15] = '{0, 0, 1, 1, 8'h00, 8'h10, 2'b01, 0};

        // Reset held low, then idle edges with En=0.
        #2;
        chk("reset_q", 32'(Q), 32'h00);
        chk("reset_flags", 32'({Digit_wrap, Rollover}), 32'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle%0d", i), 32'({Q, Digit_wrap, Rollover}), 32'h0);
        end

        // Up cascade 00..99 and back to 00.
        set_in(0, 0, 1, 1, 8'h00);
        for (int e = 1; e <= 100; e++) begin
            int p, n;
            logic [1:0] dw;
            p  = e - 1;
            n  = e % 100;
            dw = {p == 99, p % 10 == 9};
            tick();
            chk($sformatf("up_edge%0d", e), 32'({Q, Digit_wrap, Rollover}),
                32'({bcd(n), dw, p == 99}));
        end
        tick();
        chk("up_after_roll", 32'({Q, Digit_wrap, Rollover}), 32'({8'h01, 2'b00, 1'b0}));

        // Table: priority, saturation, down wrap, suppressed wrap, direction change.
        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
            tick();
            chk($sformatf("vec%0d", i), 32'({Q, Digit_wrap, Rollover}),
                32'({vecs[i].q, vecs[i].dw, vecs[i].ro}));
        end

        // Async reset mid-count at 47, observed before the next edge.
        set_in(0, 1, 0, 0, 8'h47);
        tick();
        chk("load47", 32'(Q), 32'h47);
        set_in(0, 0, 1, 1, 8'h00);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_q", 32'(Q), 32'h00);
        #1;
        Reset_n = 1'b1;
        tick();
        chk("post_reset_count", 32'({Q, Digit_wrap, Rollover}), 32'({8'h01, 2'b00, 1'b0}));
        set_in(0, 0, 0, 0, 8'h00);

        // Mod-6 single digit: 0..5 then wrap with Rollover only after the sixth edge.
        En6 = 1; Up6 = 1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk($sformatf("k6_edge%0d", e), 32'({Q6, Digit_wrap6, Rollover6}),
                32'({3'(e % 6), e == 6, e == 6}));
        end
        En6 = 0;
        tick();
        chk("k6_hold", 32'({Q6, Digit_wrap6, Rollover6}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/mod_counter_chain.md
Name: mod_counter_chain

Overview:
- Parametrised successor to the single mod-k rollover counter: a cascade of DIGITS identical mod-K digit counters, each W bits wide.
- Adds count enable, up/down direction, synchronous clear, synchronous parallel load, and per-digit plus whole-chain wrap flags.
- Drives multi-digit displays and timers (e.g. BCD seconds/minutes) and tick dividers in the lab designs.

Parameters:
- DIGITS, 4, number of cascaded digits; must be ≥1.
- W, 4, bits per digit.
- K, 10, modulus of every digit; 2 ≤ K ≤ 2^W; digit counts 0..K-1.

Ports:
- Clock  input  1  rising-edge clock
- Reset_n  input  1  reset, asynchronous, active-low
- En  input  1  count enable; one count step per enabled edge
- Up  input  1  1 = count up, 0 = count down; sampled each edge
- Clear  input  1  synchronous clear to all-zero
- Load  input  1  synchronous parallel load
- Load_val  input  DIGITS*W  load value; digit i at bits [i*W +: W], digit 0 least significant
- Q  output  DIGITS*W  count value, same packing as Load_val
- Digit_wrap  output  DIGITS  registered; bit i high for one cycle after digit i wrapped
- Rollover  output  1  registered; high for one cycle after the whole chain wrapped

Behaviour:
- Reset (Reset_n low, asynchronous): Q = 0, Digit_wrap = 0, Rollover = 0. Held while low; first count occurs on the first rising edge after release.
- Priority per rising edge: Clear > Load > En > hold.
- Clear: Q ← 0; Digit_wrap ← 0; Rollover ← 0.
- Load: each digit ← Load_val digit, saturated to K-1 if ≥ K; Digit_wrap ← 0; Rollover ← 0.
- En = 0 (no Clear/Load): Q holds; Digit_wrap ← 0; Rollover ← 0. Flags are strictly one-cycle pulses.
- Up count (En = 1, Up = 1):
  - Digit 0 always steps. Digit i > 0 steps only if every lower digit is at K-1 before the edge.
  - Stepping digit: if value < K-1 then +1; else → 0 and its wrap flag is set.
- Down count (En = 1, Up = 0):
  - Digit i > 0 steps only if every lower digit is 0 before the edge.
  - Stepping digit: if 0 then → K-1 with wrap flag set; else -1.
- Digit_wrap[i] ← 1 on the edge where digit i wraps, else 0. It becomes visible in the same cycle as the wrapped Q value (registered alongside Q, no extra latency).
- Rollover ← 1 on the edge where digit DIGITS-1 wraps, which implies all digits wrap together: up from all-(K-1) to 0, or down from 0 to all-(K-1).
- Latency: Q and flags update on the enabling edge. Carry decision is combinational across digits within one cycle, with no ripple delay in cycles.
- Direction change mid-count: takes effect on the next edge with no glitch state. Wrap is judged from the pre-edge value and the current Up.
- Clear or Load asserted together with a would-be wrap: the wrap is suppressed and flags stay 0.
- Arithmetic per digit is modulo K in W bits. No overflow beyond W is possible given the saturated load and K ≤ 2^W.

Decomposition:
- Shared package counter_pkg: constants for default DIGITS, W, K, and the BCD modulus (10) / sexagesimal tens modulus (6) used by clock designs.
- Sub-module mod_digit (parameters W, K), one per digit.
  - Inputs: Clock, Reset_n, step, Up, Clear, Load, load value.
  - Outputs: value, at_term (K-1 when up, 0 when down), wrap flag.
- Top: generate loop over digits plus the AND-chain of at_term that builds each digit's step enable.

Test Plan:
- Reset/idle: DIGITS=2, K=10, Reset_n low then high, En=0 for 5 edges → Q=0x00 throughout, Digit_wrap=0, Rollover=0.
- Up cascade: En=1, Up=1 from 0 for 100 edges → Q steps 00..99. Digit_wrap[0] pulses after 09→10 and every tenth edge. At edge 100 Q=00 with Rollover=1 and Digit_wrap=2'b11 for exactly one cycle.
- Down wrap: Load 00, then En=1, Up=0 for one edge → Q=99, Rollover=1, Digit_wrap=11. Next edge → Q=98, flags 0.
- Load saturation and priority: Load_val=0xC5 (digit1=12), Load=1 → Q=95. Clear=1 and Load=1 together → Q=00.
- Suppressed wrap: Q=99, En=1, Up=1 with Clear=1 → Q=00, Rollover=0. Async Reset_n pulse mid-count at Q=47 → Q=00 immediately, before the next edge.
- Alternate modulus: K=6, W=3, DIGITS=1, up for 6 edges → 0,1,2,3,4,5,0 with Rollover high only on the cycle after the sixth edge.
